spu_permute_pipe: RTL and testbench

Parametrised successor to the SPU-Lite odd-pipe shift/rotate unit.
- Computes quadword bit/byte shifts and rotates, plus new per-element word and halfword shifts/rotates, over a configurable datapath width.
- Carries each result down a configurable-depth pipeline with per-stage valid, hold (stall) and flush (branch kill).
- Exposes every stage's RT address/data/valid as forwarding taps, then writes back to the register file.

---
 rtl/spu_permute_pipe.sv | 189 ++++++++++++++++++
 tb/tb_spu_permute_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spu_permute_pipe.sv
// spu_permute_pipe
//
// Permute/shift/rotate unit: quadword bit and byte shifts/rotates plus
// per-element word and halfword shifts/rotates, computed combinationally
// and then carried down a DEPTH-stage pipeline. The pipeline supports a
// whole-pipe hold and a flush that kills the youngest KILL_DEPTH stages.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   in_valid     issue strobe
//   in_op        operation select (0..8 defined, 9..15 give zero)
//   in_imm_sel   1: count from in_I7, 0: count from in_RB
//   in_RA        source operand
//   in_RB        count operand
//   in_I7        immediate count
//   in_RT_addr   destination register address
//   hold         freeze the whole pipeline
//   flush        kill the youngest KILL_DEPTH stages (wins over hold)
//   fwd_valid    per-stage valid, bit k-1 = stage k
//   fwd_addr     per-stage address, slice k-1 = stage k
//   fwd_data     per-stage data, slice k-1 = stage k
//   out_valid    write enable (stage DEPTH valid)
//   out_RT_addr  write-back address (stage DEPTH)
//   out_RT       write-back data (stage DEPTH)
module spu_permute_pipe #(
  parameter int DATA_WD    = 128,
  parameter int ADDR_WD    = 7,
  parameter int DEPTH      = 8,
  parameter int KILL_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [3:0]               in_op,
  input  logic                     in_imm_sel,
  input  logic [DATA_WD-1:0]       in_RA,
  input  logic [DATA_WD-1:0]       in_RB,
  input  logic [6:0]               in_I7,
  input  logic [ADDR_WD-1:0]       in_RT_addr,
  input  logic                     hold,
  input  logic                     flush,
  output logic [DEPTH-1:0]         fwd_valid,
  output logic [DEPTH*ADDR_WD-1:0] fwd_addr,
  output logic [DEPTH*DATA_WD-1:0] fwd_data,
  output logic                     out_valid,
  output logic [ADDR_WD-1:0]       out_RT_addr,
  output logic [DATA_WD-1:0]       out_RT
);

  localparam int unsigned NBYTES = DATA_WD / 8;
  localparam int          NWORDS = DATA_WD / 32;
  localparam int          NHALFS = DATA_WD / 16;

  localparam logic [3:0] OP_SHLQBI = 4'd0;
  localparam logic [3:0] OP_ROTQBI = 4'd1;
  localparam logic [3:0] OP_SHLQBY = 4'd2;
  localparam logic [3:0] OP_ROTQBY = 4'd3;
  localparam logic [3:0] OP_SHRQBY = 4'd4;
  localparam logic [3:0] OP_SHLW   = 4'd5;
  localparam logic [3:0] OP_ROTW   = 4'd6;
  localparam logic [3:0] OP_SHLH   = 4'd7;
  localparam logic [3:0] OP_ROTH   = 4'd8;

  // Per-word shift/rotate. Word counts use 6 bits so counts of 32..63 clear
  // the element on a shift; rotates only look at the low 5 bits.
  function automatic logic [DATA_WD-1:0] word_op(
    input logic [DATA_WD-1:0] a,
    input logic [DATA_WD-1:0] b,
    input logic [6:0]         imm,
    input logic               use_imm,
    input logic               rot
  );
    logic [DATA_WD-1:0] r;
    logic [31:0]        w;
    logic [5:0]         c;
    logic [63:0]        d;
    r = '0;
    for (int e = 0; e < NWORDS; e++) begin
      w = a[32*e +: 32];
      c = use_imm ? imm[5:0] : b[32*e +: 6];
      d = {w, w} << c[4:0];
      if (rot) r[32*e +: 32] = d[63:32];
      else if (!c[5]) r[32*e +: 32] = w << c[4:0];
    end
    return r;
  endfunction

  // Per-halfword shift/rotate, same scheme with 5-bit counts.
  function automatic logic [DATA_WD-1:0] half_op(
    input logic [DATA_WD-1:0] a,
    input logic [DATA_WD-1:0] b,
    input logic [6:0]         imm,
    input logic               use_imm,
    input logic               rot
  );
    logic [DATA_WD-1:0] r;
    logic [15:0]        h;
    logic [4:0]         c;
    logic [31:0]        d;
    r = '0;
    for (int e = 0; e < NHALFS; e++) begin
      h = a[16*e +: 16];
      c = use_imm ? imm[4:0] : b[16*e +: 5];
      d = {h, h} << c[3:0];
      if (rot) r[16*e +: 16] = d[31:16];
      else if (!c[4]) r[16*e +: 16] = h << c[3:0];
    end
    return r;
  endfunction

  logic [2:0]           bit_cnt;
  logic [4:0]           byte_cnt;
  int unsigned          byte_idx;
  logic [2*DATA_WD-1:0] dbl;
  logic [DATA_WD-1:0]   result;
  logic                 accept;

  // Rotates are taken from the upper half of the operand doubled and shifted.
  // The byte range check uses whichever count source is selected, so an
  // immediate byte shift never looks at RB.
  always_comb begin
    bit_cnt  = in_imm_sel ? in_I7[2:0] : in_RB[2:0];
    byte_cnt = in_imm_sel ? in_I7[4:0] : in_RB[4:0];
    byte_idx = 32'(byte_cnt);
    dbl      = '0;
    result   = '0;
    case (in_op)
      OP_SHLQBI: result = in_RA << bit_cnt;
      OP_ROTQBI: begin
        dbl    = {in_RA, in_RA} << bit_cnt;
        result = dbl[2*DATA_WD-1 -: DATA_WD];
      end
      OP_SHLQBY: if (byte_idx < NBYTES) result = in_RA << (8 * byte_idx);
      OP_ROTQBY: begin
        dbl    = {in_RA, in_RA} << (8 * (byte_idx % NBYTES));
        result = dbl[2*DATA_WD-1 -: DATA_WD];
      end
      OP_SHRQBY: if (byte_idx < NBYTES) result = in_RA >> (8 * byte_idx);
      OP_SHLW:   result = word_op(in_RA, in_RB, in_I7, in_imm_sel, 1'b0);
      OP_ROTW:   result = word_op(in_RA, in_RB, in_I7, in_imm_sel, 1'b1);
      OP_SHLH:   result = half_op(in_RA, in_RB, in_I7, in_imm_sel, 1'b0);
      OP_ROTH:   result = half_op(in_RA, in_RB, in_I7, in_imm_sel, 1'b1);
      default:   result = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{in_RB, in_I7[6]};

  assign accept = in_valid & ~hold & ~flush;

  logic [DEPTH-1:0]   stg_valid;
  logic [ADDR_WD-1:0] stg_addr [DEPTH];
  logic [DATA_WD-1:0] stg_data [DEPTH];

  // Flush kills the ops that sit in stages 1..KILL_DEPTH when it is raised:
  // they keep moving (so stage KILL_DEPTH+1 still loads stage KILL_DEPTH),
  // but their valid is cleared. Older stages advance even under hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stg_addr[k] <= '0;
        stg_data[k] <= '0;
      end
    end else if (flush || !hold) begin
      stg_valid[0] <= accept;
      stg_addr[0]  <= in_RT_addr;
      stg_data[0]  <= result;
      for (int k = 1; k < DEPTH; k++) begin
        stg_valid[k] <= stg_valid[k-1] & ~(flush & (k <= KILL_DEPTH));
        stg_addr[k]  <= stg_addr[k-1];
        stg_data[k]  <= stg_data[k-1];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    assign fwd_addr[k*ADDR_WD +: ADDR_WD] = stg_addr[k];
    assign fwd_data[k*DATA_WD +: DATA_WD] = stg_data[k];
  end

  assign fwd_valid   = stg_valid;
  assign out_valid   = stg_valid[DEPTH-1];
  assign out_RT_addr = stg_addr[DEPTH-1];
  assign out_RT      = stg_data[DEPTH-1];

endmodule

// File: tb/tb_spu_permute_pipe.sv
// tb_spu_permute_pipe
//
// Directed bench: a table of single-op vectors with hand-computed results on
// the default 128-bit / depth-8 unit, then hand-written sequences for reset,
// hold, flush and flush+hold, and a 64-bit / depth-2 instance.
module tb_spu_permute_pipe;

  localparam int DW = 128;
  localparam int AW = 7;
  localparam int DP = 8;
  localparam int NV = 15;

  localparam logic [127:0] RA_PAT = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid;
  logic [3:0]       in_op;
  logic             in_imm_sel;
  logic [DW-1:0]    in_RA;
  logic [DW-1:0]    in_RB;
  logic [6:0]       in_I7;
  logic [AW-1:0]    in_RT_addr;
  logic             hold;
  logic             flush;
  logic [DP-1:0]    fwd_valid;
  logic [DP*AW-1:0] fwd_addr;
  logic [DP*DW-1:0] fwd_data;
  logic             out_valid;
  logic [AW-1:0]    out_RT_addr;
  logic [DW-1:0]    out_RT;

  logic             s_valid;
  logic [3:0]       s_op;
  logic             s_imm;
  logic [63:0]      s_ra;
  logic [63:0]      s_rb;
  logic [6:0]       s_i7;
  logic [AW-1:0]    s_addr;
  logic             s_hold;
  logic             s_flush;
  logic [1:0]       s_fwd_valid;
  logic [2*AW-1:0]  s_fwd_addr;
  logic [127:0]     s_fwd_data;
  logic             s_out_valid;
  logic [AW-1:0]    s_out_addr;
  logic [63:0]      s_out_rt;

  spu_permute_pipe #(.DATA_WD(DW), .ADDR_WD(AW), .DEPTH(DP), .KILL_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_op(in_op), .in_imm_sel(in_imm_sel),
    .in_RA(in_RA), .in_RB(in_RB), .in_I7(in_I7), .in_RT_addr(in_RT_addr),
    .hold(hold), .flush(flush), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .out_valid(out_valid), .out_RT_addr(out_RT_addr), .out_RT(out_RT)
  );

  spu_permute_pipe #(.DATA_WD(64), .ADDR_WD(AW), .DEPTH(2), .KILL_DEPTH(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_op(s_op), .in_imm_sel(s_imm),
    .in_RA(s_ra), .in_RB(s_rb), .in_I7(s_i7), .in_RT_addr(s_addr),
    .hold(s_hold), .flush(s_flush), .fwd_valid(s_fwd_valid), .fwd_addr(s_fwd_addr),
    .fwd_data(s_fwd_data), .out_valid(s_out_valid), .out_RT_addr(s_out_addr), .out_RT(s_out_rt)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic         imm;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [6:0]   i7;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[NV];
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic setVec(input int idx, input string name, input logic [3:0] op, input logic imm,
                        input logic [127:0] ra, input logic [127:0] rb, input logic [6:0] i7,
                        input logic [127:0] exp);
    vecs[idx].name = name;
    vecs[idx].op   = op;
    vecs[idx].imm  = imm;
    vecs[idx].ra   = ra;
    vecs[idx].rb   = rb;
    vecs[idx].i7   = i7;
    vecs[idx].exp  = exp;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    hold       = 1'b0;
    flush      = 1'b0;
    in_op      = 4'd0;
    in_imm_sel = 1'b0;
    in_RA      = '0;
    in_RB      = '0;
    in_I7      = '0;
    in_RT_addr = '0;
  endtask

  task automatic issue(input logic [3:0] op, input logic imm, input logic [127:0] ra,
                       input logic [127:0] rb, input logic [6:0] i7, input logic [AW-1:0] addr);
    in_valid   = 1'b1;
    in_op      = op;
    in_imm_sel = imm;
    in_RA      = ra;
    in_RB      = rb;
    in_I7      = i7;
    in_RT_addr = addr;
  endtask

  task automatic applyStimulus(input vec_t v, input logic [AW-1:0] addr);
    @(negedge clk);
    idle();
    issue(v.op, v.imm, v.ra, v.rb, v.i7, addr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic early;
    logic stale;

    setVec(0,  "shlqby_c3",   4'd2, 1'b0, RA_PAT, 128'd3,  7'd0,
           128'h3344_5566_7788_99AA_BBCC_DDEE_FF00_0000);
    setVec(1,  "shlqby_c16",  4'd2, 1'b0, RA_PAT, 128'd16, 7'd0, 128'h0);
    setVec(2,  "rotqby_c17",  4'd3, 1'b0, RA_PAT, 128'd17, 7'd0,
           128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00);
    setVec(3,  "shlqbi_i45",  4'd0, 1'b1, RA_PAT, 128'd0,  7'h45,
           128'h0224_4668_8AAC_CEF1_1335_5779_9BBD_DFE0);
    setVec(4,  "rotqbi_rb3",  4'd1, 1'b0, 128'hF000_0000_0000_0000_0000_0000_0000_000F, 128'd3, 7'd0,
           128'h8000_0000_0000_0000_0000_0000_0000_007F);
    setVec(5,  "shrqby_c2",   4'd4, 1'b0, RA_PAT, 128'd2,  7'd0,
           128'h0000_0011_2233_4455_6677_8899_AABB_CCDD);
    setVec(6,  "shrqby_i16",  4'd4, 1'b1, RA_PAT, 128'd0,  7'h10, 128'h0);
    setVec(7,  "shlqby_i2",   4'd2, 1'b1, RA_PAT, 128'd31, 7'h02,
           128'h2233_4455_6677_8899_AABB_CCDD_EEFF_0000);
    setVec(8,  "rotqby_i31",  4'd3, 1'b1, RA_PAT, 128'd0,  7'h1F,
           128'hFF00_1122_3344_5566_7788_99AA_BBCC_DDEE);
    setVec(9,  "shlw",        4'd5, 1'b0, {4{32'h8765_4321}}, {32'd63, 32'd32, 32'd31, 32'd1}, 7'd0,
           {32'h0, 32'h0, 32'h8000_0000, 32'h0ECA_8642});
    setVec(10, "rotw",        4'd6, 1'b0, {4{32'h8000_0001}}, {32'd31, 32'd33, 32'd0, 32'd4}, 7'd0,
           {32'hC000_0000, 32'h0000_0003, 32'h8000_0001, 32'h0000_0018});
    setVec(11, "roth_16_17",  4'd8, 1'b0, {8{16'h8001}}, {96'h0, 16'd17, 16'd16}, 7'd0,
           {{6{16'h8001}}, 16'h0003, 16'h8001});
    setVec(12, "shlh_i4",     4'd7, 1'b1, {8{16'h8001}}, 128'd0, 7'h04, {8{16'h0010}});
    setVec(13, "shlh_15_16",  4'd7, 1'b0, {8{16'h8001}}, {96'h0, 16'd15, 16'd16}, 7'd0,
           {{6{16'h8001}}, 16'h8000, 16'h0000});
    setVec(14, "op12_zero",   4'd12, 1'b0, RA_PAT, 128'd5, 7'd0, 128'h0);

    idle();
    s_valid = 1'b0; s_op = '0; s_imm = 1'b0; s_ra = '0; s_rb = '0; s_i7 = '0; s_addr = '0;
    s_hold = 1'b0; s_flush = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_fwd_valid", 128'(fwd_valid), 128'h0);
    checkOutput("rst_fwd_addr", 128'(fwd_addr == '0), 128'h1);
    checkOutput("rst_fwd_data", 128'(fwd_data == '0), 128'h1);
    checkOutput("rst_out_valid", 128'(out_valid), 128'h0);
    checkOutput("rst_out_addr", 128'(out_RT_addr), 128'h0);
    checkOutput("rst_out_rt", out_RT, 128'h0);
    checkOutput("rst_s_out_valid", 128'(s_out_valid), 128'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven single ops: exact latency and result for each.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i], AW'(i + 1));
      @(negedge clk);
      idle();
      early = out_valid;
      for (int j = 1; j < DP; j++) begin
        @(posedge clk);
        #1;
        if (j < DP - 1 && out_valid) early = 1'b1;
      end
      checkOutput({vecs[i].name, "_early"}, 128'(early), 128'h0);
      checkOutput({vecs[i].name, "_valid"}, 128'(out_valid), 128'h1);
      checkOutput({vecs[i].name, "_addr"}, 128'(out_RT_addr), 128'(i + 1));
      checkOutput({vecs[i].name, "_data"}, out_RT, vecs[i].exp);
    end
    repeat (3) @(negedge clk);

    // Ten back-to-back ops with a three-cycle hold after the fifth.
    // Op i: SHLQBI by 1 of (i+1), address 10+i.
    for (int e = 1; e <= 22; e++) begin
      @(negedge clk);
      idle();
      if (e <= 5) issue(4'd0, 1'b1, 128'(e), 128'd0, 7'd1, AW'(9 + e));
      else if (e <= 8) hold = 1'b1;
      else if (e <= 13) issue(4'd0, 1'b1, 128'(e - 3), 128'd0, 7'd1, AW'(6 + e));
      @(posedge clk);
      #1;
      checkOutput($sformatf("hold_valid_e%0d", e), 128'(out_valid), 128'(e >= 11 && e <= 20));
      if (e >= 11 && e <= 20) begin
        checkOutput($sformatf("hold_addr_e%0d", e), 128'(out_RT_addr), 128'(10 + e - 11));
        checkOutput($sformatf("hold_data_e%0d", e), out_RT, 128'(2 * (e - 10)));
      end
      if (e == 7) begin
        checkOutput("hold_fwd_valid", 128'(fwd_valid), 128'h1F);
        for (int k = 1; k <= 5; k++) begin
          checkOutput($sformatf("hold_fwd_addr_s%0d", k), 128'(fwd_addr[(k-1)*AW +: AW]), 128'(15 - k));
          checkOutput($sformatf("hold_fwd_data_s%0d", k), fwd_data[(k-1)*DW +: DW], 128'(2 * (6 - k)));
        end
      end
    end
    repeat (3) @(negedge clk);

    // Flush: O1..O3 (0x20..0x22), A (0x30), B (0x31), then C (0x32) with flush.
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      idle();
      if (e <= 3) issue(4'd12, 1'b0, RA_PAT, 128'd0, 7'd0, AW'(8'h1F + e));
      else if (e <= 6) issue(4'd12, 1'b0, RA_PAT, 128'd0, 7'd0, AW'(8'h2C + e));
      if (e == 6) flush = 1'b1;
      @(posedge clk);
      #1;
      if (e == 5) checkOutput("flush_pre_fwd_valid", 128'(fwd_valid), 128'h1F);
      if (e == 6) begin
        checkOutput("flush_post_fwd_valid", 128'(fwd_valid), 128'h38);
        checkOutput("flush_post_s4_addr", 128'(fwd_addr[3*AW +: AW]), 128'h22);
      end
      if (e >= 7) begin
        checkOutput($sformatf("flush_valid_e%0d", e), 128'(out_valid), 128'(e >= 8 && e <= 10));
        if (e >= 8 && e <= 10)
          checkOutput($sformatf("flush_addr_e%0d", e), 128'(out_RT_addr), 128'(8'h20 + e - 8));
      end
    end
    repeat (2) @(negedge clk);

    // Flush together with hold: stages above KILL_DEPTH still advance.
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      idle();
      if (e <= 3) issue(4'd12, 1'b0, RA_PAT, 128'd0, 7'd0, AW'(8'h3F + e));
      if (e == 4) begin
        hold  = 1'b1;
        flush = 1'b1;
      end
      @(posedge clk);
      #1;
      if (e == 3) checkOutput("fh_pre_fwd_valid", 128'(fwd_valid), 128'h07);
      if (e == 4) begin
        checkOutput("fh_post_fwd_valid", 128'(fwd_valid), 128'h08);
        checkOutput("fh_post_s4_addr", 128'(fwd_addr[3*AW +: AW]), 128'h40);
      end
      if (e >= 5) begin
        checkOutput($sformatf("fh_valid_e%0d", e), 128'(out_valid), 128'(e == 8));
        if (e == 8) checkOutput("fh_addr", 128'(out_RT_addr), 128'h40);
      end
    end
    repeat (2) @(negedge clk);

    // Reset with five ops in flight, then no stale write-back after release.
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      idle();
      issue(4'd2, 1'b0, RA_PAT, 128'd1, 7'd0, AW'(8'h50 + e));
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1;
    checkOutput("midrst_fwd_valid", 128'(fwd_valid), 128'h0);
    checkOutput("midrst_fwd_addr", 128'(fwd_addr == '0), 128'h1);
    checkOutput("midrst_fwd_data", 128'(fwd_data == '0), 128'h1);
    checkOutput("midrst_out_rt", out_RT, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    stale = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (out_valid || fwd_valid != '0) stale = 1'b1;
    end
    checkOutput("midrst_stale", 128'(stale), 128'h0);

    // 64-bit, depth-2 instance: latency 2, byte range at N=8, unused opcode.
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (e == 1) begin
        s_valid = 1'b1; s_op = 4'd2; s_imm = 1'b0; s_ra = 64'h0123_4567_89AB_CDEF;
        s_rb = 64'd8; s_i7 = 7'd0; s_addr = 7'd1;
      end else if (e == 2) begin
        s_valid = 1'b1; s_op = 4'd2; s_imm = 1'b1; s_ra = 64'h0123_4567_89AB_CDEF;
        s_rb = 64'd0; s_i7 = 7'd7; s_addr = 7'd2;
      end else if (e == 3) begin
        s_valid = 1'b1; s_op = 4'd12; s_imm = 1'b0; s_ra = 64'h0123_4567_89AB_CDEF;
        s_rb = 64'd3; s_i7 = 7'd0; s_addr = 7'd3;
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("small_valid_e%0d", e), 128'(s_out_valid), 128'(e >= 2 && e <= 4));
      if (e == 2) checkOutput("small_c8_data", 128'(s_out_rt), 128'h0);
      if (e == 3) checkOutput("small_c7_data", 128'(s_out_rt), 128'hEF00_0000_0000_0000);
      if (e == 4) checkOutput("small_op12_data", 128'(s_out_rt), 128'h0);
      if (e >= 2 && e <= 4) checkOutput($sformatf("small_addr_e%0d", e), 128'(s_out_addr), 128'(e - 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
